// File: rtl/reg_file_sb_if.sv
// Register-file bus: read ports, two write-back ports, issue port and scoreboard view.
interface reg_file_sb_if #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RD_PORTS = 2
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic                         ready;
    logic [RD_PORTS*ADDR_W-1:0]   rd_addr;
    logic [RD_PORTS*XLEN-1:0]     rd_data;
    logic [RD_PORTS-1:0]          rd_busy;
    logic                         wb0_en;
    logic [ADDR_W-1:0]            wb0_addr;
    logic [XLEN-1:0]              wb0_data;
    logic                         wb1_en;
    logic [ADDR_W-1:0]            wb1_addr;
    logic [XLEN-1:0]              wb1_data;
    logic                         issue_en;
    logic [ADDR_W-1:0]            issue_addr;
    logic [DEPTH-1:0]             busy_vec;

    // Pipeline side: drives addresses, write-backs and issues
    modport master (
        output rd_addr, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
               issue_en, issue_addr,
        input  ready, rd_data, rd_busy, busy_vec
    );

    // Register-file side
    modport slave (
        input  rd_addr, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
               issue_en, issue_addr,
        output ready, rd_data, rd_busy, busy_vec
    );
endinterface

// File: rtl/reg_file_sb.sv
// Multi-port register file with write-first bypass, RAW scoreboard and post-reset clear sweep.
module reg_file_sb #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned RD_PORTS = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    reg_file_sb_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [XLEN-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [DEPTH-1:0]  set_vec;
    logic [DEPTH-1:0]  clr_vec;
    logic              run_c;
    logic              sweep_last_c;
    logic              wb0_eff_c;
    logic              wb1_eff_c;
    logic              issue_eff_c;
    logic              wb0_drop_c;
    logic [ADDR_W-1:0] ra_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: leave INIT on the edge that clears the last register
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (sweep_last_c) state_d = S_RUN;
            S_RUN:   state_d = S_RUN;
            default: state_d = S_INIT;
        endcase
    end

    // Output decode from state
    always_comb begin
        run_c     = 1'b0;
        bus.ready = 1'b0;
        if (state_q == S_RUN) begin
            run_c     = 1'b1;
            bus.ready = 1'b1;
        end
    end

    // Sweep counter; one extra bit so completion never wraps to 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == S_INIT) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // Effective-write / issue qualification
    always_comb begin
        sweep_last_c = (cnt_q == CNT_W'(DEPTH - 1));
        wb0_eff_c    = bus.wb0_en   && run_c && !(ZERO_REG && (bus.wb0_addr   == '0));
        wb1_eff_c    = bus.wb1_en   && run_c && !(ZERO_REG && (bus.wb1_addr   == '0));
        issue_eff_c  = bus.issue_en && run_c && !(ZERO_REG && (bus.issue_addr == '0));
        wb0_drop_c   = wb1_eff_c && (bus.wb1_addr == bus.wb0_addr);
    end

    // Storage: zero fill during INIT, dual write-back during RUN (wb1 wins a collision)
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            mem[cnt_q[ADDR_W-1:0]] <= '0;
        end else begin
            if (wb0_eff_c && !wb0_drop_c) begin
                mem[bus.wb0_addr] <= bus.wb0_data;
            end
            if (wb1_eff_c) begin
                mem[bus.wb1_addr] <= bus.wb1_data;
            end
        end
    end

    // Read ports: zero reg, then wb1 bypass, then wb0 bypass, then array
    always_comb begin
        bus.rd_data = '0;
        bus.rd_busy = '0;
        ra_c        = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            ra_c = bus.rd_addr[i*ADDR_W +: ADDR_W];
            if (run_c) begin
                if (ZERO_REG && (ra_c == '0)) begin
                    bus.rd_data[i*XLEN +: XLEN] = '0;
                end else if (wb1_eff_c && (bus.wb1_addr == ra_c)) begin
                    bus.rd_data[i*XLEN +: XLEN] = bus.wb1_data;
                end else if (wb0_eff_c && (bus.wb0_addr == ra_c)) begin
                    bus.rd_data[i*XLEN +: XLEN] = bus.wb0_data;
                end else begin
                    bus.rd_data[i*XLEN +: XLEN] = mem[ra_c];
                end
                bus.rd_busy[i] = busy_q[ra_c]
                                 && !(wb0_eff_c && (bus.wb0_addr == ra_c))
                                 && !(wb1_eff_c && (bus.wb1_addr == ra_c));
            end
        end
    end

    // Scoreboard update: a new producer (issue) overrides a same-cycle write-back
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_eff_c) set_vec[bus.issue_addr] = 1'b1;
        if (wb0_eff_c)   clr_vec[bus.wb0_addr]   = 1'b1;
        if (wb1_eff_c)   clr_vec[bus.wb1_addr]   = 1'b1;
        busy_d = (busy_q & ~clr_vec) | set_vec;
    end

    // Scoreboard register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign bus.busy_vec = busy_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: default config (A) and 4-port/64-bit/no-zero-reg config (B).
module tb_reg_file_sb;
    localparam int K_READY = 0;
    localparam int K_RDATA = 1;
    localparam int K_RBUSY = 2;
    localparam int K_BUSY  = 3;
    localparam int K_BVEC  = 4;

    logic clk;
    logic rst_n;

    reg_file_sb_if #(.XLEN(32), .ADDR_W(5), .RD_PORTS(2)) bus_a ();
    reg_file_sb_if #(.XLEN(64), .ADDR_W(4), .RD_PORTS(4)) bus_b ();

    reg_file_sb #(.XLEN(32), .ADDR_W(5), .RD_PORTS(2), .ZERO_REG(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a)
    );
    reg_file_sb #(.XLEN(64), .ADDR_W(4), .RD_PORTS(4), .ZERO_REG(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b)
    );

    int          errors = 0;
    int          checks = 0;
    int          q_kind[$];
    int          q_dut[$];
    int          q_idx[$];
    logic [63:0] q_exp[$];
    string       q_name[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1);
    end

    task automatic expect_val(input int kind, input int dut, input int idx,
                              input logic [63:0] exp, input string name);
        q_kind.push_back(kind);
        q_dut.push_back(dut);
        q_idx.push_back(idx);
        q_exp.push_back(exp);
        q_name.push_back(name);
    endtask

    function automatic logic [63:0] actual(input int kind, input int dut, input int idx);
        logic [63:0] v;
        v = '0;
        if (dut == 0) begin
            case (kind)
                K_READY: v = 64'(bus_a.ready);
                K_RDATA: v = 64'(bus_a.rd_data[idx*32 +: 32]);
                K_RBUSY: v = 64'(bus_a.rd_busy[idx]);
                K_BUSY:  v = 64'(bus_a.busy_vec[idx]);
                default: v = 64'(bus_a.busy_vec);
            endcase
        end else begin
            case (kind)
                K_READY: v = 64'(bus_b.ready);
                K_RDATA: v = bus_b.rd_data[idx*64 +: 64];
                K_RBUSY: v = 64'(bus_b.rd_busy[idx]);
                K_BUSY:  v = 64'(bus_b.busy_vec[idx]);
                default: v = 64'(bus_b.busy_vec);
            endcase
        end
        return v;
    endfunction

    // Monitor: pop every expectation queued for this cycle and compare mid-cycle
    always @(negedge clk) begin
        logic [63:0] act;
        logic [63:0] exp;
        string       nm;
        int          kd;
        int          du;
        int          ix;
        while (q_kind.size() > 0) begin
            kd  = q_kind.pop_front();
            du  = q_dut.pop_front();
            ix  = q_idx.pop_front();
            exp = q_exp.pop_front();
            nm  = q_name.pop_front();
            act = actual(kd, du, ix);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL %s: actual=%h required=%h", nm, act, exp);
            end
        end
    end

    task automatic clear_en();
        bus_a.wb0_en = 1'b0;  bus_a.wb1_en = 1'b0;  bus_a.issue_en = 1'b0;
        bus_b.wb0_en = 1'b0;  bus_b.wb1_en = 1'b0;  bus_b.issue_en = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_en();
    endtask

    task automatic rd_a(input int port, input int addr);
        bus_a.rd_addr[port*5 +: 5] = 5'(addr);
    endtask

    task automatic rd_b(input int port, input int addr);
        bus_b.rd_addr[port*4 +: 4] = 4'(addr);
    endtask

    initial begin
        logic [63:0] bx;
        logic [63:0] by;
        logic [63:0] bz;
        logic [63:0] bw;
        bx = 64'h0123_4567_89AB_CDEF;
        by = 64'hFEDC_BA98_7654_3210;
        bz = 64'h1111_2222_3333_4444;
        bw = 64'h5555_6666_7777_8888;

        rst_n = 1'b0;
        bus_a.rd_addr = '0;  bus_a.wb0_addr = '0;  bus_a.wb0_data = '0;
        bus_a.wb1_addr = '0; bus_a.wb1_data = '0;  bus_a.issue_addr = '0;
        bus_b.rd_addr = '0;  bus_b.wb0_addr = '0;  bus_b.wb0_data = '0;
        bus_b.wb1_addr = '0; bus_b.wb1_data = '0;  bus_b.issue_addr = '0;
        clear_en();

        // Held in reset
        repeat (3) @(posedge clk);
        #1;
        expect_val(K_READY, 0, 0, 64'd0, "reset_ready_a");
        expect_val(K_BVEC,  0, 0, 64'd0, "reset_busy_vec_a");
        expect_val(K_RDATA, 0, 0, 64'd0, "reset_rd_data_a");
        expect_val(K_RBUSY, 0, 0, 64'd0, "reset_rd_busy_a");
        expect_val(K_READY, 1, 0, 64'd0, "reset_ready_b");

        // Release: A sweeps 32 cycles, B sweeps 16
        next_cycle();
        rst_n = 1'b1;
        for (int k = 0; k <= 32; k++) begin
            if (k > 0) next_cycle();
            expect_val(K_READY, 0, 0, 64'(k >= 32), "sweep_ready_a");
            expect_val(K_READY, 1, 0, 64'(k >= 16), "sweep_ready_b");
            if (k == 3) begin
                bus_a.wb0_en = 1'b1; bus_a.wb0_addr = 5'd5; bus_a.wb0_data = 32'hDEAD_BEEF;
                rd_a(0, 5);
                expect_val(K_RDATA, 0, 0, 64'd0, "init_rd_forced_zero");
                expect_val(K_RBUSY, 0, 0, 64'd0, "init_rd_busy_zero");
            end
        end

        next_cycle();
        rd_a(0, 5);
        expect_val(K_RDATA, 0, 0, 64'd0, "init_write_ignored");
        checks++;
        if (bus_a.ready !== 1'b1) begin
            errors++;
            $display("FAIL direct_ready_a: actual=%b required=1", bus_a.ready);
        end
        checks++;
        if (bus_b.ready !== 1'b1) begin
            errors++;
            $display("FAIL direct_ready_b: actual=%b required=1", bus_b.ready);
        end

        // wb0/wb1 collision on register 7
        next_cycle();
        bus_a.wb0_en = 1'b1; bus_a.wb0_addr = 5'd7; bus_a.wb0_data = 32'h1111_1111;
        bus_a.wb1_en = 1'b1; bus_a.wb1_addr = 5'd7; bus_a.wb1_data = 32'h2222_2222;
        rd_a(1, 7);
        expect_val(K_RDATA, 0, 1, 64'h2222_2222, "wb_prio_bypass");
        next_cycle();
        expect_val(K_RDATA, 0, 1, 64'h2222_2222, "wb_prio_array");
        next_cycle();
        expect_val(K_RDATA, 0, 1, 64'h2222_2222, "wb_prio_array_later");

        // Register 0 hardwired
        next_cycle();
        bus_a.wb1_en = 1'b1; bus_a.wb1_addr = 5'd0; bus_a.wb1_data = 32'hFFFF_FFFF;
        bus_a.issue_en = 1'b1; bus_a.issue_addr = 5'd0;
        rd_a(0, 0);
        expect_val(K_RDATA, 0, 0, 64'd0, "zero_reg_bypass");
        next_cycle();
        expect_val(K_RDATA, 0, 0, 64'd0, "zero_reg_array");
        expect_val(K_BUSY,  0, 0, 64'd0, "zero_reg_not_busy");
        checks++;
        if (bus_a.busy_vec[0] !== 1'b0) begin
            errors++;
            $display("FAIL direct_zero_reg_not_busy: actual=%b required=0", bus_a.busy_vec[0]);
        end

        // Issue / write-back on register 9
        next_cycle();
        bus_a.issue_en = 1'b1; bus_a.issue_addr = 5'd9;
        rd_a(0, 9);
        expect_val(K_RBUSY, 0, 0, 64'd0, "issue_rd_busy_same_cycle");
        expect_val(K_BUSY,  0, 9, 64'd0, "issue_busy_vec_same_cycle");
        next_cycle();
        expect_val(K_BUSY,  0, 9, 64'd1, "issue_busy_vec");
        expect_val(K_RBUSY, 0, 0, 64'd1, "issue_rd_busy");
        checks++;
        if (bus_a.busy_vec[9] !== 1'b1) begin
            errors++;
            $display("FAIL direct_issue_busy_vec: actual=%b required=1", bus_a.busy_vec[9]);
        end
        next_cycle();
        bus_a.wb0_en = 1'b1; bus_a.wb0_addr = 5'd9; bus_a.wb0_data = 32'hABCD_0001;
        expect_val(K_RBUSY, 0, 0, 64'd0, "wb_rd_busy_clear");
        expect_val(K_RDATA, 0, 0, 64'hABCD_0001, "wb_bypass_data");
        expect_val(K_BUSY,  0, 9, 64'd1, "wb_busy_vec_still_set");
        next_cycle();
        expect_val(K_BUSY,  0, 9, 64'd0, "wb_busy_vec_clear");
        expect_val(K_RDATA, 0, 0, 64'hABCD_0001, "wb_array_data");

        // Issue and write-back to register 3 in the same cycle
        next_cycle();
        bus_a.issue_en = 1'b1; bus_a.issue_addr = 5'd3;
        bus_a.wb1_en = 1'b1; bus_a.wb1_addr = 5'd3; bus_a.wb1_data = 32'h3333_3333;
        rd_a(1, 3);
        expect_val(K_RDATA, 0, 1, 64'h3333_3333, "issue_wb_bypass");
        next_cycle();
        rd_a(0, 3);
        expect_val(K_BUSY,  0, 3, 64'd1, "issue_wb_busy");
        expect_val(K_RDATA, 0, 0, 64'h3333_3333, "issue_wb_array");
        expect_val(K_RBUSY, 0, 0, 64'd1, "issue_wb_rd_busy");

        // Make 3 and 9 busy, write nonzero to 5
        bus_a.issue_en = 1'b1; bus_a.issue_addr = 5'd9;
        bus_a.wb0_en = 1'b1; bus_a.wb0_addr = 5'd5; bus_a.wb0_data = 32'h5555_5555;
        next_cycle();
        expect_val(K_BVEC,  0, 0, 64'h208, "busy_vec_3_9");

        // Parameter-sweep instance
        bus_b.issue_en = 1'b1; bus_b.issue_addr = 4'd0;
        rd_b(0, 0);
        expect_val(K_RBUSY, 1, 0, 64'd0, "b_issue_r0_same_cycle");
        next_cycle();
        expect_val(K_BUSY,  1, 0, 64'd1, "b_r0_busy");
        bus_b.wb0_en = 1'b1; bus_b.wb0_addr = 4'd0; bus_b.wb0_data = bx;
        bus_b.wb1_en = 1'b1; bus_b.wb1_addr = 4'd1; bus_b.wb1_data = by;
        rd_b(0, 0); rd_b(1, 1);
        expect_val(K_RDATA, 1, 0, bx, "b_r0_bypass");
        expect_val(K_RBUSY, 1, 0, 64'd0, "b_r0_rd_busy_wb");
        expect_val(K_RDATA, 1, 1, by, "b_r1_bypass");
        next_cycle();
        expect_val(K_BUSY,  1, 0, 64'd0, "b_r0_busy_clear");
        bus_b.wb0_en = 1'b1; bus_b.wb0_addr = 4'd2; bus_b.wb0_data = bz;
        bus_b.wb1_en = 1'b1; bus_b.wb1_addr = 4'd3; bus_b.wb1_data = bw;
        rd_b(2, 2); rd_b(3, 3);
        expect_val(K_RDATA, 1, 0, bx, "b_p0_r0");
        expect_val(K_RDATA, 1, 1, by, "b_p1_r1");
        expect_val(K_RDATA, 1, 2, bz, "b_p2_r2_bypass");
        expect_val(K_RDATA, 1, 3, bw, "b_p3_r3_bypass");
        next_cycle();
        rd_b(0, 3); rd_b(1, 2); rd_b(2, 1); rd_b(3, 0);
        expect_val(K_RDATA, 1, 0, bw, "b_p0_r3");
        expect_val(K_RDATA, 1, 1, bz, "b_p1_r2");
        expect_val(K_RDATA, 1, 2, by, "b_p2_r1");
        expect_val(K_RDATA, 1, 3, bx, "b_p3_r0");

        // Asynchronous reset pulse between edges
        next_cycle();
        rst_n = 1'b0;
        expect_val(K_READY, 0, 0, 64'd0, "async_rst_ready_a");
        expect_val(K_BVEC,  0, 0, 64'd0, "async_rst_busy_vec_a");
        expect_val(K_READY, 1, 0, 64'd0, "async_rst_ready_b");
        #1;
        checks++;
        if (bus_a.ready !== 1'b0) begin
            errors++;
            $display("FAIL direct_async_ready_a: actual=%b required=0", bus_a.ready);
        end
        checks++;
        if (bus_a.busy_vec !== 32'h0) begin
            errors++;
            $display("FAIL direct_async_busy_vec_a: actual=%h required=0", bus_a.busy_vec);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            next_cycle();
            expect_val(K_READY, 0, 0, 64'(k >= 32), "resweep_ready_a");
            expect_val(K_READY, 1, 0, 64'(k >= 16), "resweep_ready_b");
        end
        for (int j = 0; j < 16; j++) begin
            next_cycle();
            rd_a(0, 2 * j);
            rd_a(1, 2 * j + 1);
            expect_val(K_RDATA, 0, 0, 64'd0, "resweep_clear_a_even");
            expect_val(K_RDATA, 0, 1, 64'd0, "resweep_clear_a_odd");
            if (j < 4) begin
                for (int p = 0; p < 4; p++) begin
                    rd_b(p, 4 * j + p);
                    expect_val(K_RDATA, 1, p, 64'd0, "resweep_clear_b");
                end
            end
        end
        expect_val(K_BVEC, 0, 0, 64'd0, "resweep_busy_vec_a");
        expect_val(K_BVEC, 1, 0, 64'd0, "resweep_busy_vec_b");

        next_cycle();
        @(negedge clk);
        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised multi-port integer register file with a built-in scoreboard, the next-generation register file for the processor core. It provides RD_PORTS combinational read ports and two write-back ports with write-first bypass. It also provides per-register pending-write tracking so the issue stage can detect RAW hazards. After reset, a hardware sweep clears the array, so storage can map to RAM without an initial block.

## Interface
- XLEN, 32, register width in bits
- ADDR_W, 5, register address width; DEPTH = 2**ADDR_W registers
- RD_PORTS, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 is hardwired to zero (writes and issues to it ignored); 0 = register 0 is ordinary storage

- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- ready  out  1  high when the init sweep is done and the block accepts writes/issues
- rd_addr  in  RD_PORTS*ADDR_W  read addresses, port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  RD_PORTS*XLEN  read data, port i at bits [i*XLEN +: XLEN]
- rd_busy  out  RD_PORTS  port i's register has a write pending that is not satisfied this cycle
- wb0_en / wb0_addr / wb0_data  in  1 / ADDR_W / XLEN  write-back port 0
- wb1_en / wb1_addr / wb1_data  in  1 / ADDR_W / XLEN  write-back port 1 (priority port)
- issue_en / issue_addr  in  1 / ADDR_W  mark destination register pending
- busy_vec  out  DEPTH  scoreboard bits, bit a = register a pending

## Operation
- **States:** INIT, RUN.
  - rst_n low: state=INIT, sweep counter=0, busy_vec=0.
- **INIT:**
  - Each cycle writes 0 to array[counter], then counter+1.
  - After writing DEPTH-1, go to RUN on the next edge, so INIT lasts exactly DEPTH cycles after rst_n rises.
  - During INIT: ready=0, wb*/issue ignored, rd_data forced to 0, rd_busy forced to 0.
- **RUN:** ready=1; stays in RUN until rst_n is asserted.
- **Reset mid-sweep or mid-RUN:** immediately abandon; INIT restarts from address 0 when rst_n rises.
- **Write:**
  - A write-back port is effective when its en=1, state=RUN, and not (ZERO_REG=1 and addr=0).
  - Both ports effective on the same address: wb1 data is stored and wb0 is dropped.
  - Different addresses: both are stored in the same cycle.
- **Read (combinational), per port, in priority order:**
  1. ZERO_REG=1 and addr=0 -> 0
  2. effective wb1 to addr -> wb1_data
  3. effective wb0 to addr -> wb0_data
  4. otherwise array[addr]
- **Scoreboard, per register a, on each edge in RUN:**
  - An effective issue to a sets busy[a].
  - Otherwise, any effective write-back to a clears busy[a].
  - Issue and write-back to the same a in one cycle: busy stays 1, because the new producer wins.
  - Issue to an already-busy register: stays 1; the next write-back to it clears it (no producer counting).
  - Issue to register 0 is ignored when ZERO_REG=1; register 0 is never busy then.
- **rd_busy[i]** = busy[rd_addr_i] AND NOT (effective write-back to rd_addr_i this cycle). A bypassed value counts as available.

## Timing
- **Reset values:** ready=0, busy_vec=0, rd_data=0, rd_busy=0.
- **Read latency:**
  - 0 cycles, combinational from rd_addr, wb*, and state.
  - A write is visible through bypass in its own cycle and from the array on all following cycles.
- **Scoreboard latency:**
  - busy_vec is registered; a change is visible the cycle after the issue or write-back edge.
  - issue_en in cycle n -> busy_vec bit high from cycle n+1; rd_busy of a reader in cycle n does not see it.
- **ready:** rises on the edge that ends the DEPTH-th INIT cycle; goes to 0 asynchronously with rst_n.
- **Addresses:** all are ADDR_W bits; there is no out-of-range case. The sweep counter is ADDR_W+1 bits so it can detect completion without wrap.

## Test plan
- **Reset sweep:** release rst_n with DEPTH=32 -> ready=0 for exactly 32 cycles, then 1. A wb0 write of 0xDEADBEEF to register 5 during INIT is ignored, and reading register 5 after ready returns 0.
- **Bypass and priority:**
  - In one cycle, wb0 writes 0x11111111 and wb1 writes 0x22222222, both to register 7; rd port 1 on register 7 reads 0x22222222 that cycle and on every later cycle.
  - wb1 to register 0 with ZERO_REG=1 -> reads of register 0 stay 0.
- **Scoreboard:**
  - issue register 9 -> busy_vec[9]=1 next cycle; a read of register 9 shows rd_busy=1.
  - In the write-back cycle (wb0 register 9 = 0xABCD0001), rd_busy=0 and rd_data=0xABCD0001; busy_vec[9]=0 next cycle.
- **Simultaneous issue and write-back:** issue register 3 and wb1 register 3 in the same cycle -> busy_vec[3]=1 afterwards and the array holds wb1_data.
- **Reset mid-operation:**
  - Set busy on registers 3 and 9 and write nonzero values, then pulse rst_n low asynchronously between edges.
  - Required: ready and busy_vec go to 0 immediately, INIT reruns for 32 cycles, and afterwards all registers read 0.
- **Parameter sweep:** RD_PORTS=4, XLEN=64, ADDR_W=4, ZERO_REG=0 -> INIT lasts 16 cycles, register 0 is writable and can become busy, and 4 simultaneous reads return independent values.
